// File: rtl/step_pulse_pkg.sv
// Shared types and helpers for the N-axis step pulse generator.
// State encoding, one-hot test and period counter sizing.
package step_pulse_pkg;

    typedef enum logic [2:0] {
        HOME_SETUP,
        HOME_RUN,
        HOME_DONE,
        IDLE,
        MOVE_SETUP,
        MOVE_RUN,
        MOVE_DONE
    } state_t;

    function automatic logic onehot_check(input logic [31:0] v);
        return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
    endfunction

    function automatic int period_w(input int div);
        return (div > 2) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/pulse_timer.sv
// Step period timer: counts 0..DIV-1 while running.
// Level is high for the first HIGH counts of each period.
module pulse_timer
    import step_pulse_pkg::*;
#(
    parameter int DIV  = 100,
    parameter int HIGH = 50
) (
    input  logic sysclk,
    input  logic rst_n,
    input  logic i_run,
    input  logic i_clr,
    output logic o_level,
    output logic o_period_end
);

    localparam int PW = period_w(DIV);
    localparam logic [PW-1:0] LAST = PW'(DIV - 1);
    localparam logic [PW-1:0] HI   = PW'(HIGH);

    logic [PW-1:0] r_cnt;

    // period counter, held at zero when cleared, wraps at DIV-1
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_run) begin
            r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + PW'(1);
        end
    end

    assign o_level      = (r_cnt < HI);
    assign o_period_end = i_run && (r_cnt == LAST);

endmodule

// File: rtl/step_pulse_gen.sv
// N-axis stepper pulse generator: sequential homing of every axis,
// then bounded relative moves on one selected axis at a time.
module step_pulse_gen
    import step_pulse_pkg::*;
#(
    parameter int N_AXIS   = 6,
    parameter int CNT_W    = 10,
    parameter int DIV      = 100,
    parameter int HIGH     = 50,
    parameter int HOME_MAX = 1023
) (
    input  logic              sysclk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [N_AXIS-1:0] axis_sel,
    input  logic [CNT_W-1:0]  pulse_num,
    input  logic              dir,
    input  logic              home_req,
    input  logic [N_AXIS-1:0] stop,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [N_AXIS-1:0] init_flag,
    output logic [N_AXIS-1:0] pu,
    output logic [N_AXIS-1:0] mf
);

    localparam int AX_W = (N_AXIS > 1) ? $clog2(N_AXIS) : 1;
    localparam int HC_W = $clog2(HOME_MAX + 1);
    localparam logic [AX_W-1:0] LAST_AX = AX_W'(N_AXIS - 1);
    localparam logic [HC_W-1:0] HMAX_M1 = HC_W'(HOME_MAX - 1);

    state_t            r_state, w_state_nxt;
    logic [AX_W-1:0]   r_axis, w_axis_nxt;
    logic [CNT_W-1:0]  r_rem, w_rem_nxt;
    logic [HC_W-1:0]   r_hcnt, w_hcnt_nxt;
    logic              r_dir, w_dir_nxt;
    logic              r_busy, w_busy_nxt;
    logic              r_done, w_done_nxt;
    logic              r_err, w_err_nxt;
    logic [N_AXIS-1:0] r_flag, w_flag_nxt;
    logic [N_AXIS-1:0] r_mf, w_mf_nxt;
    logic [N_AXIS-1:0] r_pu, w_pu_nxt;
    logic [N_AXIS-1:0] r_stop_s1, r_stop_s2;

    logic              w_run, w_level, w_pend;
    logic              w_stop_act, w_sel_ok;
    logic              w_pu_on, w_adv;
    logic [AX_W-1:0]   w_sel_idx;

    // two-flop synchroniser for the raw origin switches
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            r_stop_s1 <= '0;
            r_stop_s2 <= '0;
        end else begin
            r_stop_s1 <= stop;
            r_stop_s2 <= r_stop_s1;
        end
    end

    assign w_run      = (r_state == HOME_RUN) || (r_state == MOVE_RUN);
    assign w_stop_act = r_stop_s2[r_axis];

    pulse_timer #(
        .DIV  (DIV),
        .HIGH (HIGH)
    ) u_timer (
        .sysclk       (sysclk),
        .rst_n        (rst_n),
        .i_run        (w_run),
        .i_clr        (!w_run),
        .o_level      (w_level),
        .o_period_end (w_pend)
    );

    // one-hot select to index, and move acceptance test
    always_comb begin
        w_sel_idx = '0;
        for (int i = 0; i < N_AXIS; i++) begin
            if (axis_sel[i]) w_sel_idx = AX_W'(i);
        end
        w_sel_ok = onehot_check(32'(axis_sel)) && |(axis_sel & r_flag);
    end

    // next state and next register values
    always_comb begin
        w_state_nxt = r_state;
        w_axis_nxt  = r_axis;
        w_rem_nxt   = r_rem;
        w_hcnt_nxt  = r_hcnt;
        w_dir_nxt   = r_dir;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
        w_flag_nxt  = r_flag;
        w_mf_nxt    = r_mf;
        w_pu_on     = 1'b0;
        w_adv       = 1'b0;
        w_pu_nxt    = '0;
        unique case (r_state)
            HOME_SETUP: begin
                w_mf_nxt[r_axis]   = 1'b0;
                w_flag_nxt[r_axis] = 1'b0;
                w_hcnt_nxt         = '0;
                w_busy_nxt         = 1'b1;
                w_state_nxt        = HOME_RUN;
            end
            HOME_RUN: begin
                if (w_stop_act) begin
                    w_flag_nxt[r_axis] = 1'b1;
                    w_adv              = 1'b1;
                end else if (w_pend && (r_hcnt == HMAX_M1)) begin
                    w_err_nxt = 1'b1;
                    w_adv     = 1'b1;
                end else begin
                    w_pu_on = 1'b1;
                    if (w_pend) w_hcnt_nxt = r_hcnt + HC_W'(1);
                end
                if (w_adv) begin
                    if (r_axis == LAST_AX) begin
                        w_state_nxt = HOME_DONE;
                    end else begin
                        w_axis_nxt  = r_axis + AX_W'(1);
                        w_state_nxt = HOME_SETUP;
                    end
                end
            end
            HOME_DONE: begin
                w_done_nxt  = 1'b1;
                w_busy_nxt  = 1'b0;
                w_state_nxt = IDLE;
            end
            IDLE: begin
                if (home_req) begin
                    w_axis_nxt  = '0;
                    w_state_nxt = HOME_SETUP;
                end else if (start) begin
                    if (w_sel_ok) begin
                        w_axis_nxt  = w_sel_idx;
                        w_rem_nxt   = pulse_num;
                        w_dir_nxt   = dir;
                        w_state_nxt = MOVE_SETUP;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
            end
            MOVE_SETUP: begin
                w_busy_nxt       = 1'b1;
                w_mf_nxt[r_axis] = r_dir;
                w_state_nxt      = (r_rem == '0) ? MOVE_DONE : MOVE_RUN;
            end
            MOVE_RUN: begin
                if (w_stop_act && !r_dir) begin
                    w_err_nxt   = 1'b1;
                    w_done_nxt  = 1'b1;
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = IDLE;
                end else begin
                    w_pu_on = 1'b1;
                    if (w_pend) begin
                        w_rem_nxt = r_rem - CNT_W'(1);
                        if (r_rem == CNT_W'(1)) w_state_nxt = MOVE_DONE;
                    end
                end
            end
            MOVE_DONE: begin
                w_done_nxt  = 1'b1;
                w_busy_nxt  = 1'b0;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = HOME_SETUP;
                w_axis_nxt  = '0;
            end
        endcase
        if (w_pu_on && (w_state_nxt == r_state)) begin
            w_pu_nxt[r_axis] = w_level;
        end
    end

    // state and output registers
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= HOME_SETUP;
            r_axis  <= '0;
            r_rem   <= '0;
            r_hcnt  <= '0;
            r_dir   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_flag  <= '0;
            r_mf    <= '0;
            r_pu    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_axis  <= w_axis_nxt;
            r_rem   <= w_rem_nxt;
            r_hcnt  <= w_hcnt_nxt;
            r_dir   <= w_dir_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
            r_flag  <= w_flag_nxt;
            r_mf    <= w_mf_nxt;
            r_pu    <= w_pu_nxt;
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;
    assign init_flag = r_flag;
    assign pu        = r_pu;
    assign mf        = r_mf;

endmodule

// File: tb/tb_step_pulse_gen.sv
// Bench for step_pulse_gen: homing, moves, abort, rejects, re-home, reset.
// Moves are checked every cycle against an arithmetic timing model.
module tb_step_pulse_gen;

    localparam int N    = 6;
    localparam int CW   = 10;
    localparam int DIV  = 100;
    localparam int HIGH = 50;
    localparam int HMAX = 12;

    logic          sysclk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [N-1:0]  axis_sel;
    logic [CW-1:0] pulse_num;
    logic          dir;
    logic          home_req;
    logic [N-1:0]  stop;
    logic          busy;
    logic          done;
    logic          err;
    logic [N-1:0]  init_flag;
    logic [N-1:0]  pu;
    logic [N-1:0]  mf;

    step_pulse_gen #(
        .N_AXIS   (N),
        .CNT_W    (CW),
        .DIV      (DIV),
        .HIGH     (HIGH),
        .HOME_MAX (HMAX)
    ) dut (
        .sysclk    (sysclk),
        .rst_n     (rst_n),
        .start     (start),
        .axis_sel  (axis_sel),
        .pulse_num (pulse_num),
        .dir       (dir),
        .home_req  (home_req),
        .stop      (stop),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .init_flag (init_flag),
        .pu        (pu),
        .mf        (mf)
    );

    always #5 sysclk = ~sysclk;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int rises[N];
    int snap[N];
    int done_cnt = 0;
    int err_cnt = 0;
    int done_cyc = -1;
    int fr_cyc = -1;
    logic [N-1:0] prev_pu = '0;

    bit   mon_en = 1'b0;
    int   m_kind = 0;
    int   m_t = 0;
    int   m_n = 0;
    int   m_sel = 0;
    int   m_abort = -1;
    logic m_dir = 1'b0;

    int k, r0, d0, e0, oth;

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
        end
    endtask

    // expected outputs from the move/reject timing rules
    task automatic compare_model();
        int n, e;
        logic wb, wd, we;
        logic [N-1:0] wp;
        n  = cyc;
        wb = 1'b0;
        wd = 1'b0;
        we = 1'b0;
        wp = '0;
        if (m_kind == 2) begin
            we = (n == m_t);
        end else if (m_kind == 1) begin
            e  = (m_abort >= 0) ? m_abort : m_t + 2 + m_n * DIV;
            wb = (n >= m_t + 1) && (n < e);
            wd = (n == e);
            we = (m_abort >= 0) && (n == e);
            if (n >= m_t + 2 && n < e && ((n - m_t - 2) % DIV) < HIGH)
                wp[m_sel] = 1'b1;
            if (n >= m_t + 1)
                chk($sformatf("cyc%0d_mf", n), 64'(mf[m_sel]), 64'(m_dir));
        end
        chk($sformatf("cyc%0d_outputs", n),
            64'({busy, done, err, pu}), 64'({wb, wd, we, wp}));
    endtask

    task automatic observe();
        logic [N-1:0] rise;
        rise = pu & ~prev_pu;
        for (int i = 0; i < N; i++) begin
            if (rise[i]) begin
                rises[i]++;
                if (fr_cyc < 0) fr_cyc = cyc;
            end
        end
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (err === 1'b1) err_cnt++;
        prev_pu = pu;
        if (mon_en) compare_model();
    endtask

    task automatic tick();
        @(posedge sysclk);
        cyc++;
        @(negedge sysclk);
        observe();
    endtask

    task automatic do_move(input int sel, input int n, input logic d);
        m_kind   = 1;
        m_sel    = sel;
        m_n      = n;
        m_dir    = d;
        m_abort  = -1;
        m_t      = cyc + 1;
        fr_cyc   = -1;
        axis_sel = N'(1) << sel;
        pulse_num = CW'(n);
        dir      = d;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        axis_sel = '0;
    endtask

    task automatic do_reject(input logic [N-1:0] v);
        m_kind    = 2;
        m_t       = cyc + 1;
        axis_sel  = v;
        pulse_num = CW'(3);
        start     = 1'b1;
        tick();
        start     = 1'b0;
        axis_sel  = '0;
        repeat (3) tick();
    endtask

    initial begin
        for (int i = 0; i < N; i++) rises[i] = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        axis_sel  = '0;
        pulse_num = '0;
        dir       = 1'b0;
        home_req  = 1'b0;
        stop      = '0;
        repeat (3) tick();
        chk("reset_ctrl", 64'({busy, done, err}), 64'(0));
        chk("reset_pu", 64'(pu), 64'(0));
        chk("reset_mf", 64'(mf), 64'(0));
        chk("reset_flag", 64'(init_flag), 64'(0));
        rst_n = 1'b1;

        // homing: origin reached after ten periods on each axis
        for (int i = 0; i < N; i++) begin
            r0 = rises[i];
            k = 0;
            while (rises[i] == r0 && k < 400) begin
                tick();
                k++;
            end
            chk($sformatf("home%0d_rise", i), 64'(rises[i] != r0), 64'(1));
            repeat (10 * DIV - 20) tick();
            stop[i] = 1'b1;
            k = 0;
            while (init_flag[i] !== 1'b1 && k < 50) begin
                tick();
                k++;
            end
            chk($sformatf("home%0d_flag", i), 64'(init_flag[i]), 64'(1));
            stop[i] = 1'b0;
        end
        k = 0;
        while (done_cnt == 0 && k < 50) begin
            tick();
            k++;
        end
        for (int i = 0; i < N; i++)
            chk($sformatf("home%0d_pulses", i), 64'(rises[i]), 64'(10));
        chk("home_flags", 64'(init_flag), 64'(6'h3F));
        chk("home_done_cnt", 64'(done_cnt), 64'(1));
        chk("home_err_cnt", 64'(err_cnt), 64'(0));
        tick();
        chk("home_busy", 64'(busy), 64'(0));

        // five-pulse move on axis 1, requests while busy are ignored
        mon_en = 1'b1;
        m_kind = 0;
        repeat (2) tick();
        snap = rises;
        d0 = done_cnt;
        do_move(1, 5, 1'b1);
        repeat (100) tick();
        start     = 1'b1;
        home_req  = 1'b1;
        axis_sel  = 6'b000001;
        pulse_num = CW'(3);
        tick();
        start     = 1'b0;
        home_req  = 1'b0;
        axis_sel  = '0;
        repeat (420) tick();
        chk("mv1_pulses", 64'(rises[1] - snap[1]), 64'(5));
        oth = 0;
        for (int i = 0; i < N; i++)
            if (i != 1) oth += rises[i] - snap[i];
        chk("mv1_other_pulses", 64'(oth), 64'(0));
        chk("mv1_done_cnt", 64'(done_cnt - d0), 64'(1));
        chk("mv1_span", 64'(done_cyc - fr_cyc), 64'(500));
        chk("mv1_mf", 64'(mf[1]), 64'(1));

        // zero-length move: done two cycles after acceptance
        do_move(4, 0, 1'b1);
        repeat (5) tick();
        chk("mv0_done_at", 64'(done_cyc - m_t), 64'(2));
        chk("mv0_mf", 64'(mf[4]), 64'(1));
        chk("mv0_no_pulse", 64'(fr_cyc), 64'(-1));

        // abort on origin switch during first pulse, dir=0
        snap = rises;
        d0 = done_cnt;
        e0 = err_cnt;
        do_move(3, 2, 1'b0);
        k = 0;
        while (fr_cyc < 0 && k < 10) begin
            tick();
            k++;
        end
        chk("abort_rise", 64'(fr_cyc >= 0), 64'(1));
        repeat (10) tick();
        stop[3] = 1'b1;
        m_abort = cyc + 3;
        repeat (10) tick();
        stop[3] = 1'b0;
        repeat (5) tick();
        chk("abort_pulses", 64'(rises[3] - snap[3]), 64'(1));
        chk("abort_err", 64'(err_cnt - e0), 64'(1));
        chk("abort_done", 64'(done_cnt - d0), 64'(1));

        // dir=1 runs through a held origin switch
        snap = rises;
        e0 = err_cnt;
        stop[3] = 1'b1;
        m_kind = 0;
        repeat (4) tick();
        do_move(3, 1, 1'b1);
        repeat (110) tick();
        chk("dir1_pulses", 64'(rises[3] - snap[3]), 64'(1));
        chk("dir1_no_err", 64'(err_cnt - e0), 64'(0));
        stop[3] = 1'b0;
        m_kind = 0;
        repeat (3) tick();

        // rejected selects
        snap = rises;
        e0 = err_cnt;
        do_reject(6'b000011);
        do_reject(6'b000000);
        chk("rej_err", 64'(err_cnt - e0), 64'(2));
        oth = 0;
        for (int i = 0; i < N; i++) oth += rises[i] - snap[i];
        chk("rej_no_pulse", 64'(oth), 64'(0));

        // re-home: switches already closed except axis 2, which times out
        mon_en = 1'b0;
        m_kind = 0;
        stop = 6'b111011;
        repeat (4) tick();
        snap = rises;
        d0 = done_cnt;
        e0 = err_cnt;
        home_req  = 1'b1;
        start     = 1'b1;
        axis_sel  = 6'b000001;
        pulse_num = CW'(3);
        tick();
        home_req  = 1'b0;
        start     = 1'b0;
        axis_sel  = '0;
        k = 0;
        while (done_cnt == d0 && k < 3000) begin
            tick();
            k++;
        end
        chk("rehome_done", 64'(done_cnt - d0), 64'(1));
        chk("rehome_ax2_pulses", 64'(rises[2] - snap[2]), 64'(HMAX));
        oth = 0;
        for (int i = 0; i < N; i++)
            if (i != 2) oth += rises[i] - snap[i];
        chk("rehome_other_pulses", 64'(oth), 64'(0));
        chk("rehome_err", 64'(err_cnt - e0), 64'(1));
        chk("rehome_flags", 64'(init_flag), 64'(6'b111011));
        stop = '0;
        repeat (3) tick();
        chk("rehome_busy", 64'(busy), 64'(0));

        // unhomed axis is refused
        mon_en = 1'b1;
        e0 = err_cnt;
        do_reject(6'b000100);
        chk("rej_unhomed", 64'(err_cnt - e0), 64'(1));

        // reset in the middle of a move
        m_kind = 0;
        repeat (2) tick();
        do_move(0, 5, 1'b0);
        repeat (150) tick();
        mon_en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_pu", 64'(pu), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_flag", 64'(init_flag), 64'(0));
        repeat (3) tick();
        rst_n = 1'b1;
        k = 0;
        while (pu == '0 && k < 50) begin
            tick();
            k++;
        end
        chk("rst_rehome_axis0", 64'(pu), 64'(6'b000001));
        chk("rst_rehome_busy", 64'(busy), 64'(1));
        chk("rst_rehome_flag", 64'(init_flag), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
